// File: rtl/key_tone_selector.sv
// Eight-key tone selector: synchronizes and debounces active-low buttons, picks the
// lowest pressed key and emits its tone half-period. Optional OCTAVE_DOWN_SW_EN adds an octave-down switch.
module key_tone_selector #(
    parameter int DEBOUNCE_CYCLES = 122880,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keys_n,
`ifdef OCTAVE_DOWN_SW_EN
    input  logic       octave_down_n,
`endif
    output logic [7:0] wave_half_period,
    output logic       note_valid,
    output logic [2:0] active_key
);

`ifdef OCTAVE_DOWN_SW_EN
    localparam int NKEYS = 9;
`else
    localparam int NKEYS = 8;
`endif
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic STATE_SILENT  = 1'b0;
    localparam logic STATE_PLAYING = 1'b1;

    logic [NKEYS-1:0] raw_n;
`ifdef OCTAVE_DOWN_SW_EN
    assign raw_n = {octave_down_n, keys_n};
`else
    assign raw_n = keys_n;
`endif

    logic [SYNC_STAGES-1:0][NKEYS-1:0] sync_q;
    logic [NKEYS-1:0] synced;
    logic [NKEYS-1:0] deb_q;
    logic [CNT_W-1:0] cnt_q [NKEYS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_n};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter clears at the flip, so it can never pass CNT_LAST and wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '1;
            for (int k = 0; k < NKEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NKEYS; k++) begin
                if (synced[k] == deb_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == CNT_LAST) begin
                    deb_q[k] <= ~deb_q[k];
                    cnt_q[k] <= '0;
                end else begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    function automatic logic [7:0] half_period_of(input logic [2:0] idx);
        case (idx)
            3'd0:    half_period_of = 8'd91;
            3'd1:    half_period_of = 8'd81;
            3'd2:    half_period_of = 8'd72;
            3'd3:    half_period_of = 8'd68;
            3'd4:    half_period_of = 8'd60;
            3'd5:    half_period_of = 8'd54;
            3'd6:    half_period_of = 8'd48;
            default: half_period_of = 8'd45;
        endcase
    endfunction

    logic       win_valid;
    logic [2:0] win_idx;
    logic [7:0] win_wave;

    // Scanning downward lets the lowest pressed index overwrite the rest.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (!deb_q[k]) begin
                win_valid = 1'b1;
                win_idx   = 3'(k);
            end
        end
        win_wave = half_period_of(win_idx);
`ifdef OCTAVE_DOWN_SW_EN
        if (!deb_q[8]) begin
            win_wave = {win_wave[6:0], 1'b1};
        end
`endif
    end

    logic state_q;
    logic next_state;

    always_comb begin
        next_state = state_q;
        case (state_q)
            STATE_SILENT:  if (win_valid)  next_state = STATE_PLAYING;
            STATE_PLAYING: if (!win_valid) next_state = STATE_SILENT;
            default:       next_state = STATE_SILENT;
        endcase
    end

    // Outputs are loaded from the next state so all three move in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= STATE_SILENT;
            wave_half_period <= 8'd0;
            note_valid       <= 1'b0;
            active_key       <= 3'd0;
        end else begin
            state_q <= next_state;
            if (next_state == STATE_PLAYING) begin
                wave_half_period <= win_wave;
                note_valid       <= 1'b1;
                active_key       <= win_idx;
            end else begin
                wave_half_period <= 8'd0;
                note_valid       <= 1'b0;
                active_key       <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_key_tone_selector.sv
// Self-checking bench for key_tone_selector with a short debounce window.
module tb_key_tone_selector;

    localparam int DEB  = 16;
    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic [7:0] keys_n;
`ifdef OCTAVE_DOWN_SW_EN
    logic       octave_down_n;
`endif
    logic [7:0] wave_half_period;
    logic       note_valid;
    logic [2:0] active_key;

    int checks = 0;
    int errors = 0;

    key_tone_selector #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .keys_n(keys_n),
`ifdef OCTAVE_DOWN_SW_EN
        .octave_down_n(octave_down_n),
`endif
        .wave_half_period(wave_half_period),
        .note_valid(note_valid),
        .active_key(active_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw levels delayed through SYNC stages, then a key's level is
    // accepted once it has differed from the accepted level for DEB consecutive cycles.
    logic [8:0] m_pipe [SYNC];
    logic [8:0] m_deb;
    int         m_run [9];
    logic [7:0] e_wave;
    logic       e_valid;
    logic [2:0] e_key;

    function automatic int tone_of(input int k);
        int t [8] = '{91, 81, 72, 68, 60, 54, 48, 45};
        return t[k];
    endfunction

    function automatic logic [8:0] raw_vec();
`ifdef OCTAVE_DOWN_SW_EN
        return {octave_down_n, keys_n};
`else
        return {1'b1, keys_n};
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_pipe[i] = '1;
        m_deb = '1;
        for (int k = 0; k < 9; k++) m_run[k] = 0;
        e_wave = 0; e_valid = 0; e_key = 0;
    endtask

    task automatic model_edge(input logic [8:0] raw);
        int w;
        e_valid = 0; e_key = 0; w = 0;
        for (int k = 7; k >= 0; k--) begin
            if (!m_deb[k]) begin
                e_valid = 1; e_key = 3'(k); w = tone_of(k);
            end
        end
`ifdef OCTAVE_DOWN_SW_EN
        if (e_valid && !m_deb[8]) w = 2 * w + 1;
`endif
        e_wave = 8'(w);
        for (int k = 0; k < 9; k++) begin
            if (m_pipe[SYNC-1][k] != m_deb[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_deb[k] = ~m_deb[k];
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
        end
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = raw;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge(raw_vec());
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if ({wave_half_period, note_valid, active_key} !== 12'h000) begin
            errors++; $display("[TB] FAIL reset_idle: got %h expected 000", {wave_half_period, note_valid, active_key});
        end
        keys_n = 8'h00;
        repeat (30) tick();
        checks++;
        if ({wave_half_period, note_valid, active_key} !== 12'h000) begin
            errors++; $display("[TB] FAIL reset_held_keys: got %h expected 000", {wave_half_period, note_valid, active_key});
        end
        keys_n = 8'hFF;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_key();
        keys_n = 8'hDF;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 40) keys_n = 8'hFF;
            checks++;
            if ({wave_half_period, note_valid, active_key} !== {e_wave, e_valid, e_key}) begin
                errors++; $display("[TB] FAIL single_model c=%0d: got %h expected %h", c, {wave_half_period, note_valid, active_key}, {e_wave, e_valid, e_key});
            end
            if (c == 18 || c == 59) begin
                checks++;
                if ({wave_half_period, note_valid, active_key} !== 12'h000) begin
                    errors++; $display("[TB] FAIL single_silent c=%0d: got %h expected 000", c, {wave_half_period, note_valid, active_key});
                end
            end
            if (c == 19 || c == 58) begin
                checks++;
                if (wave_half_period !== 8'd54 || note_valid !== 1'b1 || active_key !== 3'd5) begin
                    errors++; $display("[TB] FAIL single_latency c=%0d: got %0d/%0d/%0d expected 54/1/5", c, wave_half_period, note_valid, active_key);
                end
            end
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 15; c++) begin
                keys_n = (c < 10) ? 8'hFE : 8'hFF;
                tick();
                checks++;
                if (note_valid !== 1'b0 || {wave_half_period, note_valid, active_key} !== {e_wave, e_valid, e_key}) begin
                    errors++; $display("[TB] FAIL bounce r=%0d c=%0d: got %h expected 000", r, c, {wave_half_period, note_valid, active_key});
                end
            end
        end
        repeat (25) tick();
    endtask

    task automatic test_priority();
        logic saw_zero;
        keys_n = 8'hBF;
        repeat (25) tick();
        checks++;
        if (wave_half_period !== 8'd48 || active_key !== 3'd6 || note_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL prio_key6: got %0d/%0d/%0d expected 48/1/6", wave_half_period, note_valid, active_key);
        end
        saw_zero = 1'b0;
        keys_n = 8'hBB;
        for (int c = 0; c < 50; c++) begin
            if (c == 25) begin
                checks++;
                if (wave_half_period !== 8'd72 || active_key !== 3'd2 || note_valid !== 1'b1) begin
                    errors++; $display("[TB] FAIL prio_key2: got %0d/%0d/%0d expected 72/1/2", wave_half_period, note_valid, active_key);
                end
                keys_n = 8'hBF;
            end
            tick();
            if (wave_half_period == 8'd0) saw_zero = 1'b1;
            checks++;
            if ({wave_half_period, note_valid, active_key} !== {e_wave, e_valid, e_key}) begin
                errors++; $display("[TB] FAIL prio_model c=%0d: got %h expected %h", c, {wave_half_period, note_valid, active_key}, {e_wave, e_valid, e_key});
            end
        end
        checks++;
        if (saw_zero !== 1'b0 || wave_half_period !== 8'd48 || active_key !== 3'd6) begin
            errors++; $display("[TB] FAIL prio_return: got %0d/%0d zero_seen=%0d expected 48/6 zero_seen=0", wave_half_period, active_key, saw_zero);
        end
        keys_n = 8'hFF;
        repeat (25) tick();
    endtask

    task automatic test_simultaneous();
        logic [11:0] prev;
        int changes;
        prev = {wave_half_period, note_valid, active_key};
        changes = 0;
        keys_n = 8'h77;
        for (int c = 0; c < 25; c++) begin
            tick();
            if ({wave_half_period, note_valid, active_key} != prev) changes++;
            prev = {wave_half_period, note_valid, active_key};
        end
        checks++;
        if (changes != 1 || wave_half_period !== 8'd68 || note_valid !== 1'b1 || active_key !== 3'd3) begin
            errors++; $display("[TB] FAIL simultaneous: got %0d/%0d/%0d after %0d changes expected 68/1/3 after 1", wave_half_period, note_valid, active_key, changes);
        end
        keys_n = 8'hFF;
        repeat (25) tick();
    endtask

    task automatic test_reset_mid_note();
        keys_n = 8'hFD;
        repeat (25) tick();
        checks++;
        if (wave_half_period !== 8'd81 || note_valid !== 1'b1 || active_key !== 3'd1) begin
            errors++; $display("[TB] FAIL midreset_playing: got %0d/%0d/%0d expected 81/1/1", wave_half_period, note_valid, active_key);
        end
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({wave_half_period, note_valid, active_key} !== 12'h000) begin
            errors++; $display("[TB] FAIL midreset_async: got %h expected 000", {wave_half_period, note_valid, active_key});
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            checks++;
            if (wave_half_period !== ((c < 19) ? 8'd0 : 8'd81) || {wave_half_period, note_valid, active_key} !== {e_wave, e_valid, e_key}) begin
                errors++; $display("[TB] FAIL midreset_redebounce c=%0d: got %0d expected %0d", c, wave_half_period, (c < 19) ? 0 : 81);
            end
        end
        keys_n = 8'hFF;
        repeat (25) tick();
    endtask

`ifdef OCTAVE_DOWN_SW_EN
    task automatic test_octave();
        keys_n = 8'hFE;
        octave_down_n = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 26) octave_down_n = 1'b1;
            tick();
            checks++;
            if ({wave_half_period, note_valid, active_key} !== {e_wave, e_valid, e_key}) begin
                errors++; $display("[TB] FAIL octave_model c=%0d: got %h expected %h", c, {wave_half_period, note_valid, active_key}, {e_wave, e_valid, e_key});
            end
            if (c == 25 || c == 50) begin
                checks++;
                if (wave_half_period !== ((c == 25) ? 8'd183 : 8'd91)) begin
                    errors++; $display("[TB] FAIL octave_value c=%0d: got %0d expected %0d", c, wave_half_period, (c == 25) ? 183 : 91);
                end
            end
        end
        keys_n = 8'hFF;
        repeat (25) tick();
    endtask
`endif

    task automatic test_random();
        for (int s = 0; s < 50; s++) begin
            int hold;
            hold = $urandom_range(1, 40);
            keys_n = ($urandom_range(0, 1) == 0) ? 8'($urandom) : ~8'(1 << $urandom_range(0, 7));
`ifdef OCTAVE_DOWN_SW_EN
            octave_down_n = 1'($urandom);
`endif
            for (int c = 0; c < hold; c++) begin
                tick();
                checks++;
                if ({wave_half_period, note_valid, active_key} !== {e_wave, e_valid, e_key}) begin
                    errors++; $display("[TB] FAIL random s=%0d c=%0d: got %h expected %h", s, c, {wave_half_period, note_valid, active_key}, {e_wave, e_valid, e_key});
                end
            end
        end
        keys_n = 8'hFF;
`ifdef OCTAVE_DOWN_SW_EN
        octave_down_n = 1'b1;
`endif
        repeat (25) tick();
    endtask

    initial begin
        rst = 1'b1;
        keys_n = 8'hFF;
`ifdef OCTAVE_DOWN_SW_EN
        octave_down_n = 1'b1;
`endif
        model_reset();
        test_reset();
        test_single_key();
        test_bounce();
        test_priority();
        test_simultaneous();
        test_reset_mid_note();
`ifdef OCTAVE_DOWN_SW_EN
        test_octave();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_tone_selector.md
KEY_TONE_SELECTOR -- requirements
Module: key_tone_selector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 122880, consecutive stable clk cycles required to accept a key level change (10 ms at 12.288 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per key input; legal range 2..3.
REQ-003 Port clk  input  1  system clock, 12.288 MHz; one clock; the block is fully synchronous to it.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port keys_n  input  8  raw push-buttons, active-low, asynchronous to clk; bit 0 = C4 ... bit 7 = C5.
REQ-006 Port wave_half_period  output  8  tone half-period in audio frames for the downstream I2S transmitter; 0 = silence.
REQ-007 Port note_valid  output  1  high while a debounced key is held.
REQ-008 Port active_key  output  3  index of the key currently sounding; 0 when silent.

Function
REQ-009 Each keys_n bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-010 Each key SHALL have its own debounce counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits; the counter clears whenever the synchronized level equals the debounced level, otherwise it increments.
REQ-011 The debounced level of a key SHALL flip, and its counter clear, in the cycle the counter reaches DEBOUNCE_CYCLES-1; any reversal of the synchronized level before that cycle clears the counter with no flip.
REQ-012 Priority: among debounced-pressed keys, the lowest index SHALL win.
REQ-013 Half-period table, key 0..7: 91, 81, 72, 68, 60, 54, 48, 45 (round(48000/(2f)) - 1 for C4 D4 E4 F4 G4 A4 B4 C5).
REQ-014 Control FSM states: SILENT, PLAYING.
REQ-015 SILENT -> PLAYING when any debounced key is pressed; PLAYING -> SILENT when none are pressed; PLAYING -> PLAYING with a new active_key when the winning index changes.
REQ-016 In SILENT, outputs SHALL be wave_half_period=0, note_valid=0, active_key=0.
REQ-017 In PLAYING, outputs SHALL be the winner's table value, note_valid=1, and active_key equal to the winner index.
REQ-018 All outputs SHALL be registered and SHALL change together in a single cycle, with no intermediate values.
REQ-019 Latency: the outputs SHALL update exactly 1 cycle after the debounced-level flip, giving SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles from a stable raw edge.
REQ-020 Simultaneous events: if several keys flip in the same cycle, the outputs SHALL reflect the post-flip priority winner directly, with no transient value.
REQ-021 Counters SHALL saturate and never wrap; a key held for any duration SHALL produce no spurious flip.

Reset
REQ-022 While rst is high, all synchronizer flops SHALL be set to 1 (released), debounced levels to released, counters to 0, FSM to SILENT, and outputs to 0.
REQ-023 If rst is asserted mid-debounce or mid-note, the outputs SHALL go to 0 asynchronously.
REQ-024 After rst deasserts, a key already held SHALL require a full debounce before it sounds.

Configuration
REQ-025 Macro OCTAVE_DOWN_SW_EN: when defined, the block SHALL add input port octave_down_n (1 bit, active-low, synchronized and debounced as a ninth key).
REQ-026 With OCTAVE_DOWN_SW_EN defined and octave_down_n debounced-pressed, wave_half_period SHALL be 2*table+1 (key 0 gives 183); changing octave_down_n SHALL update the outputs 1 cycle after its debounced flip.
REQ-027 Without OCTAVE_DOWN_SW_EN, the port and its logic SHALL be absent and the outputs SHALL follow the base table only.

Verification
REQ-028 DEBOUNCE_CYCLES=16: hold keys_n[5] low for 40 cycles -> outputs 54/1/5 at cycle 2+16+1 after the edge, and 0/0/0 at the same latency after release.
REQ-029 DEBOUNCE_CYCLES=16: pulse keys_n[0] low for 10 cycles, repeated 5 times with 5-cycle gaps -> note_valid stays 0 throughout.
REQ-030 Keys 6 held then key 2 pressed -> outputs change 48 -> 72 and active_key 6 -> 2; releasing key 2 returns to 48 with no 0 between.
REQ-031 Keys 3 and 7 flip in the same cycle -> single transition to 68/1/3.
REQ-032 Assert rst during PLAYING (key 1) -> outputs 0 immediately; with the key still held after deassert, 81 appears only after a full debounce.
REQ-033 OCTAVE_DOWN_SW_EN defined, key 0 and octave held -> wave_half_period=183; octave released -> 91.
